// File: rtl/lsu_pkg.sv
// Shared FSM state type, access-size encodings and request fault check
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // A request is unissuable if its size is illegal, its address is not naturally
  // aligned, or it asks to read and write at once.
  function automatic logic req_fault(input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic [1:0] off);
    logic f;
    case (sz)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = off[0];
      SZ_WORD: f = |off;
      default: f = 1'b1;
    endcase
    return f | (rd & wr);
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Little-endian lane logic: byte enables and store replication for the request,
// lane extraction plus sign/zero extension for returning load data.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and per-size formatting of both data directions.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata_fmt = 32'h0000_0000;
    byte_s    = rdata[{offset, 3'b000} +: 8];
    half_s    = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_fmt = {{24{sign_ext & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_fmt = {{16{sign_ext & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_fmt = rdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata_fmt = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit: accepts one aligned access from the datapath, holds the core
// while the variable-latency memory answers, and reports misalignment or timeout.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state_r, state_next_s;
  logic [7:0]  cnt_r;
  logic [1:0]  size_r, off_r;
  logic        sext_r;
  logic        req_s, fault_s, accept_s, ack_s, tmo_s;
  logic        stall_s, misalign_s;
  logic [1:0]  fmt_size_s, fmt_off_s;
  logic [3:0]  be_s;
  logic [31:0] wrep_s, rfmt_s;

  assign req_s   = memread | memwrite;
  assign fault_s = req_fault(memread, memwrite, size, addr[1:0]);

  // The request path formats live inputs; once issued, the load path uses the latched ones.
  assign fmt_size_s = (state_r == IDLE) ? size : size_r;
  assign fmt_off_s  = (state_r == IDLE) ? addr[1:0] : off_r;

  lsu_lane_fmt u_lane_fmt (
    .size      (fmt_size_s),
    .offset    (fmt_off_s),
    .sign_ext  (sext_r),
    .wdata     (wdata),
    .rdata     (m_rdata),
    .be        (be_s),
    .wdata_rep (wrep_s),
    .rdata_fmt (rfmt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic plus the combinational stall/misalign handshake.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    misalign_s   = 1'b0;
    accept_s     = 1'b0;
    ack_s        = 1'b0;
    tmo_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && fault_s) begin
          misalign_s = 1'b1;
        end else if (req_s) begin
          stall_s      = 1'b1;
          accept_s     = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (m_ack) begin
          ack_s        = 1'b1;
          state_next_s = DONE;
        end else if (cnt_r == TMO_LAST) begin
          tmo_s        = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign stall    = stall_s & ~reset;
  assign misalign = misalign_s & ~reset;

  // Request latch, timeout counter, load result and bus error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'h0000_0000;
      m_be     <= 4'b0000;
      m_wdata  <= 32'h0000_0000;
      size_r   <= 2'b00;
      off_r    <= 2'b00;
      sext_r   <= 1'b0;
      cnt_r    <= 8'd0;
      readdata <= 32'h0000_0000;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (accept_s) begin
        m_req   <= 1'b1;
        m_we    <= memwrite;
        m_addr  <= {addr[31:2], 2'b00};
        m_be    <= be_s;
        m_wdata <= wrep_s;
        size_r  <= size;
        off_r   <= addr[1:0];
        sext_r  <= sign_ext;
        cnt_r   <= 8'd0;
      end else if (ack_s) begin
        // Ack takes priority over a timeout landing on the same cycle.
        m_req <= 1'b0;
        cnt_r <= 8'd0;
        if (!m_we) begin
          readdata <= rfmt_s;
        end
      end else if (tmo_s) begin
        m_req    <= 1'b0;
        cnt_r    <= 8'd0;
        bus_err  <= 1'b1;
        readdata <= 32'h0000_0000;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed self-checking bench for lsu_dmem with a scripted memory responder.
module tb_lsu_dmem;

  logic        clk, reset, memread, memwrite, sign_ext, m_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, m_rdata, readdata, m_addr, m_wdata;
  logic        stall, misalign, bus_err, m_req, m_we;
  logic [3:0]  m_be;

  int errors = 0;
  int checks = 0;

  int          obs_stall, obs_req;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rd;
  logic        obs_we, obs_berr;

  lsu_dmem #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .readdata(readdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one access; ack_at = N acks on the Nth BUSY cycle, 0 never acks.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdv, input int ack_at);
    int busy;
    obs_stall = 0; obs_req = 0; busy = 0;
    obs_be = 'x; obs_addr = 'x; obs_wdata = 'x; obs_we = 1'bx;
    @(negedge clk);
    memread = rd; memwrite = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
    #1 if (stall) obs_stall++;
    @(negedge clk);
    while (m_req && busy < 300) begin
      busy++;
      obs_req++;
      if (stall) obs_stall++;
      if (busy == 1) begin
        obs_be = m_be; obs_addr = m_addr; obs_we = m_we; obs_wdata = m_wdata;
      end
      if (busy == ack_at) begin
        m_ack = 1'b1; m_rdata = rdv;
      end
      @(negedge clk);
      m_ack = 1'b0; m_rdata = 32'hA5A5_A5A5;
    end
    if (stall) obs_stall++;
    obs_rd = readdata; obs_berr = bus_err;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; memread = 1'b1; memwrite = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h100; wdata = 32'hFFFF_FFFF; m_ack = 1'b0; m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
    checks++; if (m_req !== 1'b0 || m_we !== 1'b0 || m_be !== 4'b0000) begin
      errors++; $display("FAIL reset req/we/be: got %b %b %b expected 0 0 0000", m_req, m_we, m_be); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      errors++; $display("FAIL reset addr/wdata: got %h %h expected 0 0", m_addr, m_wdata); end
    checks++; if (readdata !== 32'h0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset readdata/bus_err: got %h %b expected 0 0", readdata, bus_err); end
    memwrite = 1'b1;
    #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset misalign: got %b expected 0", misalign); end
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0; reset = 1'b0;
  endtask

  task automatic test_word_load;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    checks++; if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_we !== 1'b0) begin
      errors++; $display("FAIL word_load req: got addr %h be %b we %b expected 100 1111 0", obs_addr, obs_be, obs_we); end
    checks++; if (obs_stall !== 2) begin errors++; $display("FAIL word_load stall_cycles: got %0d expected 2", obs_stall); end
    checks++; if (obs_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load readdata: got %h expected deadbeef", obs_rd); end
  endtask

  task automatic test_byte_load;
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8011_2233, 1);
    checks++; if (obs_be !== 4'b1000 || obs_addr !== 32'h100) begin
      errors++; $display("FAIL byte_load req: got be %b addr %h expected 1000 100", obs_be, obs_addr); end
    checks++; if (obs_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_load sext: got %h expected ffffff80", obs_rd); end
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 1);
    checks++; if (obs_rd !== 32'h0000_0080) begin errors++; $display("FAIL byte_load zext: got %h expected 00000080", obs_rd); end
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_F700, 1);
    checks++; if (obs_be !== 4'b0010 || obs_rd !== 32'hFFFF_FFF7) begin
      errors++; $display("FAIL byte_load lane1: got be %b rd %h expected 0010 fffffff7", obs_be, obs_rd); end
  endtask

  task automatic test_half_load;
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h9ABC_1234, 1);
    checks++; if (obs_be !== 4'b1100 || obs_rd !== 32'hFFFF_9ABC) begin
      errors++; $display("FAIL half_load upper: got be %b rd %h expected 1100 ffff9abc", obs_be, obs_rd); end
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h9ABC_1234, 1);
    checks++; if (obs_be !== 4'b0011 || obs_rd !== 32'h0000_1234) begin
      errors++; $display("FAIL half_load lower: got be %b rd %h expected 0011 00001234", obs_be, obs_rd); end
  endtask

  task automatic test_store;
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h206, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
    checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h204 || obs_be !== 4'b1100) begin
      errors++; $display("FAIL half_store req: got we %b addr %h be %b expected 1 204 1100", obs_we, obs_addr, obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL half_store wdata: got %h expected abcdabcd", obs_wdata); end
    checks++; if (obs_rd !== 32'h0000_1234) begin errors++; $display("FAIL store readdata_kept: got %h expected 00001234", obs_rd); end
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00C3, 32'hFFFF_FFFF, 1);
    checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hC3C3_C3C3) begin
      errors++; $display("FAIL byte_store: got be %b wdata %h expected 0010 c3c3c3c3", obs_be, obs_wdata); end
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h208, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1);
    checks++; if (obs_be !== 4'b1111 || obs_wdata !== 32'hCAFE_F00D || obs_addr !== 32'h208) begin
      errors++; $display("FAIL word_store: got be %b wdata %h addr %h expected 1111 cafef00d 208", obs_be, obs_wdata, obs_addr); end
  endtask

  task automatic test_latency;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 3);
    checks++; if (obs_stall !== 4 || obs_req !== 3) begin
      errors++; $display("FAIL latency3: got stall %0d req %0d expected 4 3", obs_stall, obs_req); end
    checks++; if (obs_rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL latency3 readdata: got %h expected 0badf00d", obs_rd); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; size = 2'b10; addr = 32'h102;
    #1;
    checks++; if (misalign !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL misalign word: got mis %b stall %b expected 1 0", misalign, stall); end
    @(negedge clk);
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL misalign word m_req: got %b expected 0", m_req); end
    memwrite = 1'b1; addr = 32'h100;
    #1;
    checks++; if (misalign !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL misalign rdwr: got mis %b stall %b expected 1 0", misalign, stall); end
    @(negedge clk);
    memwrite = 1'b0; size = 2'b11;
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign size11: got %b expected 1", misalign); end
    @(negedge clk);
    size = 2'b01; addr = 32'h101;
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign half_odd: got %b expected 1", misalign); end
    @(negedge clk);
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL misalign m_req_late: got %b expected 0", m_req); end
    memread = 1'b0;
    #1;
    checks++; if (misalign !== 1'b0 || readdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL misalign idle: got mis %b rd %h expected 0 0badf00d", misalign, readdata); end
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 0);
    checks++; if (obs_req !== 15 || obs_stall !== 16) begin
      errors++; $display("FAIL timeout cycles: got req %0d stall %0d expected 15 16", obs_req, obs_stall); end
    checks++; if (obs_berr !== 1'b1 || obs_rd !== 32'h0) begin
      errors++; $display("FAIL timeout result: got bus_err %b rd %h expected 1 0", obs_berr, obs_rd); end
    @(negedge clk);
    checks++; if (bus_err !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL timeout pulse: got bus_err %b m_req %b expected 0 0", bus_err, m_req); end
  endtask

  task automatic test_ack_at_limit;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h1357_9BDF, 15);
    checks++; if (obs_req !== 15 || obs_berr !== 1'b0 || obs_rd !== 32'h1357_9BDF) begin
      errors++; $display("FAIL ack_at_limit: got req %0d bus_err %b rd %h expected 15 0 13579bdf", obs_req, obs_berr, obs_rd); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    memread = 1'b1; size = 2'b10; addr = 32'h300;
    repeat (3) @(negedge clk);
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL reset_mid busy: got m_req %b expected 1", m_req); end
    reset = 1'b1; memread = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid async: got m_req %b stall %b expected 0 0", m_req, stall); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0 || stall !== 1'b0 || readdata !== 32'h0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid late_ack: got m_req %b stall %b rd %h bus_err %b expected 0 0 0 0",
                         m_req, stall, readdata, bus_err); end
  endtask

  task automatic test_back_to_back;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 1);
    checks++; if (obs_rd !== 32'h1111_2222 || obs_stall !== 2) begin
      errors++; $display("FAIL b2b first: got rd %h stall %0d expected 11112222 2", obs_rd, obs_stall); end
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 32'h00AB_0000, 1);
    checks++; if (obs_rd !== 32'h0000_00AB || obs_stall !== 2 || obs_be !== 4'b0100) begin
      errors++; $display("FAIL b2b second: got rd %h stall %0d be %b expected 000000ab 2 0100", obs_rd, obs_stall, obs_be); end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_load;
    test_store;
    test_latency;
    test_misalign;
    test_timeout;
    test_ack_at_limit;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
